hamming_pkt_scheduler: RTL and testbench

- Shares the single `hamming_wt_check` instance between NUM_REQ byte-stream requesters.
- Grants one requester at a time, round-robin, and streams exactly BYTES_PER_PKT contiguous bytes into the checker, with `start_of_packet` on the first byte.
- Waits for the checker's packet-complete indication, then reports the result tagged with the owner's ID.
- Recovers a hung checker by pulsing its reset after a timeout.

---
 rtl/hamming_pkt_scheduler_pkg.sv | 22 ++
 rtl/hamming_pkt_scheduler_rr_arbiter.sv | 60 ++++++
 rtl/hamming_pkt_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_hamming_pkt_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkt_scheduler_pkg.sv
// Shared types and constants for the Hamming-weight packet scheduler.
package hamming_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } sched_state_e;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned DEF_BYTES_PER_PKT = 128;
  localparam int unsigned MAX_ONES          = 31;

  // Counter width that never collapses to zero bits for tiny parameter values.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CNT_W = clog2_min1(DEF_BYTES_PER_PKT);

endpackage

// File: rtl/hamming_pkt_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer and
// moves the pointer past the winner when the grant is taken.
module hamming_rr_arbiter
  import hamming_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               any,
  output logic [IDX_W-1:0]   sel_idx,
  output logic [NUM_REQ-1:0] sel_onehot
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] shifted;
  int unsigned        cand;

  // Scan requesters starting at the pointer, first hit wins.
  always_comb begin
    any     = 1'b0;
    sel_idx = '0;
    shifted = '0;
    cand    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand    = (32'(ptr_q) + off) % NUM_REQ;
      shifted = req >> cand;
      if (!any && shifted[0]) begin
        any     = 1'b1;
        sel_idx = IDX_W'(cand);
      end
    end
    sel_onehot = any ? (NUM_REQ'(1) << sel_idx) : '0;
  end

  // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && any) begin
      if (32'(sel_idx) + 32'd1 == NUM_REQ) begin
        ptr_d = '0;
      end else begin
        ptr_d = sel_idx + IDX_W'(1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hamming_pkt_scheduler.sv
// Time-shares one Hamming-weight checker between NUM_REQ byte-stream
// requesters: grants round-robin, streams a fixed-length packet, waits for the
// checker verdict (or times out and resets it) and reports a tagged result.
module hamming_pkt_scheduler
  import hamming_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned BYTES_PER_PKT = 128,
  parameter int unsigned DONE_TIMEOUT  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_data_valid,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         req_data_ready,
  output logic                       chk_rst,
  output logic                       chk_start_of_packet,
  output logic [7:0]                 chk_packet_data,
  input  logic                       chk_last_valid,
  input  logic                       chk_wt_err,
  output logic                       busy,
  output logic                       done_valid,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic                       done_wt_err,
  output logic                       done_underrun,
  output logic                       done_timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CW    = clog2_min1(BYTES_PER_PKT);
  localparam int unsigned TW    = clog2_min1(DONE_TIMEOUT);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               underrun_q, underrun_d;
  logic [BYTE_W-1:0]  pkt_data_q, pkt_data_d;
  logic               sop_q, sop_d;
  logic               chk_rst_q, chk_rst_d;
  logic               done_valid_q, done_valid_d;
  logic [IDX_W-1:0]   done_id_q, done_id_d;
  logic               done_wt_err_q, done_wt_err_d;
  logic               done_underrun_q, done_underrun_d;
  logic               done_timeout_q, done_timeout_d;

  logic               arb_any;
  logic               arb_advance;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [BYTE_W-1:0]  cur_byte;
  logic               cur_valid;

  hamming_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .advance    (arb_advance),
    .any        (arb_any),
    .sel_idx    (arb_idx),
    .sel_onehot (arb_onehot)
  );

  // Route the granted requester's byte lane and valid bit.
  always_comb begin
    cur_byte  = '0;
    cur_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_q == IDX_W'(i)) begin
        cur_byte  = req_data[i*BYTE_W +: BYTE_W];
        cur_valid = req_data_valid[i];
      end
    end
  end

  // Packet sequencing: grant, feed, wait for verdict, one-cycle gap.
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    gnt_d           = gnt_q;
    cnt_d           = cnt_q;
    tmo_d           = tmo_q;
    underrun_d      = underrun_q;
    pkt_data_d      = '0;
    sop_d           = 1'b0;
    chk_rst_d       = 1'b0;
    done_valid_d    = 1'b0;
    done_id_d       = '0;
    done_wt_err_d   = 1'b0;
    done_underrun_d = 1'b0;
    done_timeout_d  = 1'b0;
    arb_advance     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          arb_advance = 1'b1;
          sel_d       = arb_idx;
          gnt_d       = arb_onehot;
          cnt_d       = '0;
          underrun_d  = 1'b0;
          state_d     = FEED;
        end
      end
      FEED: begin
        // The checker cannot stall, so a missing byte is padded with zero.
        pkt_data_d = cur_valid ? cur_byte : '0;
        sop_d      = (cnt_q == '0);
        if (!cur_valid) begin
          underrun_d = 1'b1;
        end
        if (cnt_q == CW'(BYTES_PER_PKT - 1)) begin
          cnt_d   = '0;
          gnt_d   = '0;
          tmo_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (chk_last_valid || chk_wt_err) begin
          done_valid_d    = 1'b1;
          done_id_d       = sel_q;
          done_wt_err_d   = chk_wt_err;
          done_underrun_d = underrun_q;
          state_d         = GAP;
        end else if (tmo_q == TW'(DONE_TIMEOUT - 1)) begin
          done_valid_d    = 1'b1;
          done_id_d       = sel_q;
          done_underrun_d = underrun_q;
          done_timeout_d  = 1'b1;
          chk_rst_d       = 1'b1;
          state_d         = GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset also drives the checker reset one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      sel_q           <= '0;
      gnt_q           <= '0;
      cnt_q           <= '0;
      tmo_q           <= '0;
      underrun_q      <= 1'b0;
      pkt_data_q      <= '0;
      sop_q           <= 1'b0;
      chk_rst_q       <= 1'b1;
      done_valid_q    <= 1'b0;
      done_id_q       <= '0;
      done_wt_err_q   <= 1'b0;
      done_underrun_q <= 1'b0;
      done_timeout_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      gnt_q           <= gnt_d;
      cnt_q           <= cnt_d;
      tmo_q           <= tmo_d;
      underrun_q      <= underrun_d;
      pkt_data_q      <= pkt_data_d;
      sop_q           <= sop_d;
      chk_rst_q       <= chk_rst_d;
      done_valid_q    <= done_valid_d;
      done_id_q       <= done_id_d;
      done_wt_err_q   <= done_wt_err_d;
      done_underrun_q <= done_underrun_d;
      done_timeout_q  <= done_timeout_d;
    end
  end

  assign gnt                 = gnt_q;
  assign req_data_ready      = gnt_q;
  assign busy                = (state_q != IDLE);
  assign chk_rst             = chk_rst_q;
  assign chk_start_of_packet = sop_q;
  assign chk_packet_data     = pkt_data_q;
  assign done_valid          = done_valid_q;
  assign done_id             = done_id_q;
  assign done_wt_err         = done_wt_err_q;
  assign done_underrun       = done_underrun_q;
  assign done_timeout        = done_timeout_q;

endmodule

// File: tb/tb_hamming_pkt_scheduler.sv
// Scoreboard bench for hamming_pkt_scheduler with a behavioural checker model.
module tb_hamming_pkt_scheduler;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned BPP     = 128;
  localparam int unsigned TMO     = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_data_valid;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   req_data_ready;
  logic                 chk_rst;
  logic                 chk_start_of_packet;
  logic [7:0]           chk_packet_data;
  logic                 chk_last_valid;
  logic                 chk_wt_err;
  logic                 busy;
  logic                 done_valid;
  logic [0:0]           done_id;
  logic                 done_wt_err;
  logic                 done_underrun;
  logic                 done_timeout;

  always #5 clk = ~clk;

  hamming_pkt_scheduler #(
    .NUM_REQ       (NUM_REQ),
    .BYTES_PER_PKT (BPP),
    .DONE_TIMEOUT  (TMO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req                 (req),
    .req_data            (req_data),
    .req_data_valid      (req_data_valid),
    .gnt                 (gnt),
    .req_data_ready      (req_data_ready),
    .chk_rst             (chk_rst),
    .chk_start_of_packet (chk_start_of_packet),
    .chk_packet_data     (chk_packet_data),
    .chk_last_valid      (chk_last_valid),
    .chk_wt_err          (chk_wt_err),
    .busy                (busy),
    .done_valid          (done_valid),
    .done_id             (done_id),
    .done_wt_err         (done_wt_err),
    .done_underrun       (done_underrun),
    .done_timeout        (done_timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { int id; int err; int und; int to; } done_t;
  typedef struct { int ones; int pad_chk; } pkt_t;

  done_t done_q[$];
  pkt_t  pkt_q[$];
  int    grant_log[$];

  // Requester byte sources: nff leading 0xFF bytes, then fill; bytes lo..hi invalid.
  int src_fill [NUM_REQ];
  int src_nff  [NUM_REQ];
  int src_lo   [NUM_REQ];
  int src_hi   [NUM_REQ];

  int chk_mode = 0;   // 0: complete, 1: complete with weight error, 2: never complete
  bit check_gap = 1'b0;
  int last_sop = -1;
  bit abort_expected = 1'b0;
  logic [7:0] pkt_bytes [BPP];

  // Byte sources: present the next byte of the packet whenever granted.
  initial begin
    int pos [NUM_REQ];
    logic [7:0] b;
    req_data       = '1;
    req_data_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) pos[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) begin
          b = (pos[i] < src_nff[i]) ? 8'hFF : 8'(src_fill[i]);
          if (pos[i] >= src_lo[i] && pos[i] <= src_hi[i]) begin
            req_data_valid[i] = 1'b0;
            b = 8'hFF;
          end else begin
            req_data_valid[i] = 1'b1;
          end
          req_data[i*8 +: 8] = b;
          pos[i]++;
        end else begin
          pos[i]             = 0;
          req_data[i*8 +: 8] = 8'hFF;
          req_data_valid[i]  = 1'b0;
        end
      end
    end
  end

  // Checker model: collects BPP bytes after a start pulse, then answers per chk_mode.
  initial begin
    int   cnt, ones, ncyc;
    bit   active;
    pkt_t e;
    cnt = 0; ones = 0; ncyc = 0; active = 1'b0;
    chk_last_valid = 1'b0;
    chk_wt_err     = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      chk_last_valid = 1'b0;
      chk_wt_err     = 1'b0;
      if (chk_rst) begin
        active = 1'b0; cnt = 0; ones = 0;
      end else begin
        if (chk_start_of_packet) begin
          check("sop_mid_packet", 32'(active), 0);
          if (check_gap && last_sop >= 0) check("sop_spacing", ncyc - last_sop, BPP + 3);
          last_sop = ncyc;
          active = 1'b1; cnt = 0; ones = 0;
        end
        if (active) begin
          pkt_bytes[cnt] = chk_packet_data;
          ones += $countones(chk_packet_data);
          cnt++;
          if (cnt == BPP) begin
            active = 1'b0;
            if (pkt_q.size() == 0) begin
              check("pkt_unexpected", 1, 0);
            end else begin
              e = pkt_q.pop_front();
              check("pkt_ones", ones, e.ones);
              if (e.pad_chk != 0) begin
                check("pad_byte9", pkt_bytes[9], 8'h01);
                check("pad_bytes10_12", {pkt_bytes[10], pkt_bytes[11], pkt_bytes[12]}, 0);
                check("pad_byte13", pkt_bytes[13], 8'h01);
              end
            end
            if (chk_mode != 2) begin
              chk_last_valid = 1'b1;
              chk_wt_err     = (chk_mode == 1);
            end
          end
        end
      end
    end
  end

  // Monitor: done scoreboard and grant length / one-hot tracking.
  initial begin
    logic [NUM_REQ-1:0] prev_gnt;
    int    run_len, idx;
    done_t e;
    prev_gnt = '0; run_len = 0; idx = 0;
    forever begin
      @(negedge clk);
      if (done_valid === 1'b1) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          e = done_q.pop_front();
          check("done_id", done_id, e.id);
          check("done_wt_err", done_wt_err, e.err);
          check("done_underrun", done_underrun, e.und);
          check("done_timeout", done_timeout, e.to);
        end
      end
      if (gnt != '0) begin
        if (prev_gnt == '0) begin
          check("gnt_onehot", 32'($onehot(gnt)), 1);
          run_len = 1;
          for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) idx = i;
          grant_log.push_back(idx);
        end else begin
          run_len++;
          if (gnt !== prev_gnt) check("gnt_stable", gnt, prev_gnt);
        end
      end else if (prev_gnt != '0) begin
        if (abort_expected) abort_expected = 1'b0;
        else check("gnt_cycles", run_len, BPP);
      end
      prev_gnt = gnt;
    end
  end

  task automatic set_src(input int id, input int fill, input int nff, input int lo, input int hi);
    src_fill[id] = fill; src_nff[id] = nff; src_lo[id] = lo; src_hi[id] = hi;
  endtask

  task automatic expect_pkt(input int id, input int err, input int und, input int to,
                            input int ones, input int pad);
    done_t d;
    pkt_t  p;
    d.id = id; d.err = err; d.und = und; d.to = to;
    p.ones = ones; p.pad_chk = pad;
    done_q.push_back(d);
    pkt_q.push_back(p);
  endtask

  task automatic wait_gnt(input int id);
    int n = 0;
    while (gnt[id] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("gnt_wait", 32'(gnt[id]), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((done_q.size() != 0 || pkt_q.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    check("done_wait", done_q.size() + pkt_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_pkt(input int id, input int mode);
    chk_mode = mode;
    req[id] = 1'b1;
    wait_gnt(id);
    req[id] = 1'b0;
    wait_drain(400);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NUM_REQ; i++) set_src(i, 1, 0, 999, 999);
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_ready", req_data_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_chk_rst", chk_rst, 1);
    check("rst_sop", chk_start_of_packet, 0);
    check("rst_data", chk_packet_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_chk_rst", chk_rst, 0);
    check("post_rst_busy", busy, 0);

    // Both requesters held: grants alternate with a gap between start pulses.
    set_src(0, 8'h01, 0, 999, 999);
    set_src(1, 8'h11, 0, 999, 999);
    chk_mode = 0;
    grant_log.delete();
    last_sop = -1;
    check_gap = 1'b1;
    expect_pkt(0, 0, 0, 0, 128, 0);
    expect_pkt(1, 0, 0, 0, 256, 0);
    expect_pkt(0, 0, 0, 0, 128, 0);
    expect_pkt(1, 0, 0, 0, 256, 0);
    req = '1;
    n = 0;
    while (grant_log.size() < 4 && n < 1000) begin @(negedge clk); n++; end
    req = '0;
    wait_drain(400);
    check_gap = 1'b0;
    check("alt_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("alt_order", grant_log[i], i % 2);

    // Single requester 0, all bytes 0x01.
    set_src(0, 8'h01, 0, 999, 999);
    expect_pkt(0, 0, 0, 0, 128, 0);
    run_pkt(0, 0);

    // Requester 1: five 0xFF bytes then zeros, checker flags weight error.
    set_src(1, 8'h00, 5, 999, 999);
    expect_pkt(1, 1, 0, 0, 40, 0);
    run_pkt(1, 1);

    // Requester 0: bytes 10..12 not valid, zero-padded.
    set_src(0, 8'h01, 0, 10, 12);
    expect_pkt(0, 0, 1, 0, 125, 1);
    run_pkt(0, 0);

    // Requester 1: checker hangs, timeout and one-cycle checker reset.
    set_src(1, 8'h03, 0, 999, 999);
    expect_pkt(1, 0, 0, 1, 256, 0);
    chk_mode = 2;
    req[1] = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    n = 0;
    while (gnt != '0 && n < 200) begin @(negedge clk); n++; end
    check("drain_entry", gnt, 0);
    n = 0;
    while (done_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("timeout_latency", n, TMO);
    check("timeout_chk_rst", chk_rst, 1);
    @(negedge clk);
    check("timeout_chk_rst_width", chk_rst, 0);
    wait_drain(100);

    // Normal packet after the timeout.
    set_src(0, 8'h80, 0, 999, 999);
    expect_pkt(0, 0, 0, 0, 128, 0);
    run_pkt(0, 0);

    // Reset at byte 60 of a requester-0 packet aborts with no result.
    set_src(0, 8'h01, 0, 999, 999);
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    repeat (60) @(negedge clk);
    abort_expected = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_gnt", gnt, 0);
    check("abort_busy", busy, 0);
    check("abort_done_valid", done_valid, 0);
    check("abort_chk_rst", chk_rst, 1);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_q.size(), 0);

    // Both requesting after reset: pointer restarts at requester 0.
    expect_pkt(0, 0, 0, 0, 128, 0);
    req = '1;
    n = 0;
    while (gnt == '0 && n < 50) begin @(negedge clk); n++; end
    req = '0;
    check("rr_after_reset", gnt, 2'b01);
    wait_drain(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
